// File: rtl/wm_but_pkg.sv
// Shared types and timing defaults for the front-panel button conditioner.
// Defaults match the FSIM tick settings kept in wm_fsim_def.v.
package wm_but_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEB_P = 3'd1,
    ST_HELD  = 3'd2,
    ST_RPT   = 3'd3,
    ST_DEB_R = 3'd4
  } but_state_e;

  localparam int unsigned DEF_DEB_MS  = 20;
  localparam int unsigned DEF_LONG_MS = 1000;
  localparam int unsigned DEF_RPT_MS  = 200;

  // One counter width covers every threshold so both counters can share it.
  function automatic int unsigned but_cnt_w(input int unsigned deb_ms,
                                            input int unsigned long_ms,
                                            input int unsigned rpt_ms);
    int unsigned max_ms;
    max_ms = deb_ms;
    if (long_ms > max_ms) max_ms = long_ms;
    if (rpt_ms > max_ms) max_ms = rpt_ms;
    return $clog2(max_ms + 1);
  endfunction

endpackage

// File: rtl/wm_but_chan.sv
// One button channel: 2-flop synchroniser, press/release debounce, long-press and
// auto-repeat timing. Repeat pulses are built only with WM_BUT_AUTO_RPT_EN defined.
module wm_but_chan
  import wm_but_pkg::*;
#(
  parameter int unsigned DEB_MS       = DEF_DEB_MS,
  parameter int unsigned LONG_MS      = DEF_LONG_MS,
  parameter int unsigned RPT_MS       = DEF_RPT_MS,
  parameter bit          BUT_ACT_HIGH = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic raw_i,
  output logic en_o,
  output logic long_o,
  output logic held_o
);

  localparam int unsigned CW = but_cnt_w(DEB_MS, LONG_MS, RPT_MS);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] DEB_C   = CW'(DEB_MS);
  localparam logic [CW-1:0] LONG_C  = CW'(LONG_MS);
`ifdef WM_BUT_AUTO_RPT_EN
  localparam logic [CW-1:0] RPT_C   = CW'(RPT_MS);
`endif
  localparam logic RELEASED_LVL = ~BUT_ACT_HIGH;

  logic          sync1_q, sync2_q;
  logic          pressed;
  but_state_e    state_q, state_d;
  logic          ret_rpt_q, ret_rpt_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          en_q, en_d;
  logic          long_q, long_d;
  logic          held_q, held_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Synchroniser resets to the released level so a held button is not seen as
  // pressed until it has crossed both flops again after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= RELEASED_LVL;
      sync2_q <= RELEASED_LVL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = BUT_ACT_HIGH ? sync2_q : ~sync2_q;

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    ret_rpt_d  = ret_rpt_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    en_d       = 1'b0;
    long_d     = 1'b0;
    held_d     = held_q;
    case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          state_d   = ST_DEB_P;
          deb_cnt_d = '0;
        end
      end
      ST_DEB_P: begin
        if (!pressed) begin
          state_d = ST_IDLE;
        end else if (tick_i) begin
          deb_cnt_d = sat_inc(deb_cnt_q);
          if (deb_cnt_d == DEB_C) begin
            state_d    = ST_HELD;
            en_d       = 1'b1;
            held_d     = 1'b1;
            hold_cnt_d = '0;
          end
        end
      end
      ST_HELD: begin
        if (!pressed) begin
          state_d   = ST_DEB_R;
          ret_rpt_d = 1'b0;
          deb_cnt_d = '0;
        end else if (tick_i) begin
          hold_cnt_d = sat_inc(hold_cnt_q);
          if (hold_cnt_d == LONG_C) begin
            state_d    = ST_RPT;
            long_d     = 1'b1;
            hold_cnt_d = '0;
          end
        end
      end
      ST_RPT: begin
        if (!pressed) begin
          state_d   = ST_DEB_R;
          ret_rpt_d = 1'b1;
          deb_cnt_d = '0;
        end
`ifdef WM_BUT_AUTO_RPT_EN
        else if (tick_i) begin
          hold_cnt_d = sat_inc(hold_cnt_q);
          if (hold_cnt_d == RPT_C) begin
            en_d       = 1'b1;
            hold_cnt_d = '0;
          end
        end
`endif
      end
      ST_DEB_R: begin
        // A bounce back to pressed resumes the hold timing where it paused.
        if (pressed) begin
          state_d = ret_rpt_q ? ST_RPT : ST_HELD;
        end else if (tick_i) begin
          deb_cnt_d = sat_inc(deb_cnt_q);
          if (deb_cnt_d == DEB_C) begin
            state_d    = ST_IDLE;
            held_d     = 1'b0;
            hold_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ret_rpt_q  <= 1'b0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      en_q       <= 1'b0;
      long_q     <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_rpt_q  <= ret_rpt_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      en_q       <= en_d;
      long_q     <= long_d;
      held_q     <= held_d;
    end
  end

  assign en_o   = en_q;
  assign long_o = long_q;
  assign held_o = held_q;

endmodule

// File: rtl/wm_but_array.sv
// Multi-channel button conditioner: N_BUT independent channels plus the buzzer
// any-press pulse. Auto-repeat is enabled by defining WM_BUT_AUTO_RPT_EN.
module wm_but_array
  import wm_but_pkg::*;
#(
  parameter int unsigned N_BUT        = 4,
  parameter int unsigned DEB_MS       = DEF_DEB_MS,
  parameter int unsigned LONG_MS      = DEF_LONG_MS,
  parameter int unsigned RPT_MS       = DEF_RPT_MS,
  parameter bit          BUT_ACT_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clkCnt_1msEnd,
  input  logic [N_BUT-1:0] but_in,
  output logic [N_BUT-1:0] but_en,
  output logic [N_BUT-1:0] but_long,
  output logic [N_BUT-1:0] but_held,
  output logic             but_any
);

  for (genvar g = 0; g < N_BUT; g++) begin : g_chan
    wm_but_chan #(
      .DEB_MS      (DEB_MS),
      .LONG_MS     (LONG_MS),
      .RPT_MS      (RPT_MS),
      .BUT_ACT_HIGH(BUT_ACT_HIGH)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .tick_i(clkCnt_1msEnd),
      .raw_i (but_in[g]),
      .en_o  (but_en[g]),
      .long_o(but_long[g]),
      .held_o(but_held[g])
    );
  end

  // Pulses are already registered per channel, so the OR stays one cycle wide.
  assign but_any = |but_en;

endmodule

// File: tb/tb_wm_but_array.sv
// Directed bench for wm_but_array: press, bounce, long/repeat, simultaneous press,
// reset mid-debounce and an active-low instance.
module tb_wm_but_array;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] but_in;
  logic [3:0] but_en, but_long, but_held;
  logic       but_any;
  logic [0:0] lo_in, lo_en, lo_long, lo_held;
  logic       lo_any;

  int n_total = 0;
  int n_pass  = 0;
  int tick_cnt = 0;
  int base;

  int   en_cnt  [4];
  int   en_tick [4][4];
  int   long_cnt[4];
  int   long_tick[4];
  logic held_seen1;
  int   any_cnt;
  int   lo_en_cnt, lo_en_tick, lo_long_cnt;

  always #4 clk = ~clk;

  wm_but_array #(.N_BUT(4), .DEB_MS(20), .LONG_MS(1000), .RPT_MS(200), .BUT_ACT_HIGH(1'b1)) u_hi (
    .clk(clk), .reset(reset), .clkCnt_1msEnd(tick), .but_in(but_in),
    .but_en(but_en), .but_long(but_long), .but_held(but_held), .but_any(but_any)
  );

  wm_but_array #(.N_BUT(1), .DEB_MS(20), .LONG_MS(1000), .RPT_MS(200), .BUT_ACT_HIGH(1'b0)) u_lo (
    .clk(clk), .reset(reset), .clkCnt_1msEnd(tick), .but_in(lo_in),
    .but_en(lo_en), .but_long(lo_long), .but_held(lo_held), .but_any(lo_any)
  );

  // Pulses only appear on the negedge after a tick negedge, never on one, so
  // reading tick_cnt here does not race its increment.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (but_en[c]) begin
        if (en_cnt[c] < 4) en_tick[c][en_cnt[c]] = tick_cnt;
        en_cnt[c]++;
      end
      if (but_long[c]) begin
        long_tick[c] = tick_cnt;
        long_cnt[c]++;
      end
    end
    if (but_held[1]) held_seen1 = 1'b1;
    if (but_any) any_cnt++;
    if (lo_en[0]) begin
      lo_en_tick = tick_cnt;
      lo_en_cnt++;
    end
    if (lo_long[0]) lo_long_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    for (int c = 0; c < 4; c++) begin
      en_cnt[c] = 0;
      long_cnt[c] = 0;
      long_tick[c] = -1;
      for (int k = 0; k < 4; k++) en_tick[c][k] = -1;
    end
    held_seen1 = 1'b0;
    any_cnt = 0;
    lo_en_cnt = 0;
    lo_en_tick = -1;
    lo_long_cnt = 0;
  endtask

  // One tick period is 4 cycles; the tick is raised on the last negedge.
  task automatic do_tick();
    repeat (3) begin
      @(negedge clk);
      tick = 1'b0;
    end
    @(negedge clk);
    tick = 1'b1;
    tick_cnt++;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    tick   = 1'b0;
    but_in = 4'b0000;
    lo_in  = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_outputs", {but_en, but_long, but_held, 3'b000, but_any}, 16'h0000);
    check("rst_lo_outputs", {lo_en, lo_long, lo_held, lo_any}, 4'b0000);
    reset = 1'b0;
    ticks(2);

    // Clean press on ch0.
    clear_mon();
    but_in[0] = 1'b1;
    base = tick_cnt;
    ticks(19);
    check("t1_held_before_accept", but_held, 4'b0000);
    ticks(1);
    idle_cycle();
    check("t1_en_one_after_tick20", but_en, 4'b0001);
    check("t1_held_rises_with_en", but_held, 4'b0001);
    idle_cycle();
    check("t1_en_one_cycle_wide", but_en, 4'b0000);
    ticks(30);
    check("t1_en_count", en_cnt[0], 1);
    check("t1_en_tick", en_tick[0][0] - base, 20);
    check("t1_other_channels_quiet", en_cnt[1] + en_cnt[2] + en_cnt[3], 0);
    but_in[0] = 1'b0;
    ticks(20);
    check("t1_held_before_release_tick", but_held[0], 1'b1);
    idle_cycle();
    check("t1_held_falls_after_release", but_held[0], 1'b0);
    ticks(5);

    // Bounce on ch1: the one-cycle glitch must restart debounce, so 5+16 ticks
    // of high level never reach acceptance.
    clear_mon();
    but_in[1] = 1'b1;
    ticks(5);
    but_in[1] = 1'b0;
    idle_cycle();
    but_in[1] = 1'b1;
    ticks(16);
    but_in[1] = 1'b0;
    ticks(25);
    check("t2_bounce_no_en", en_cnt[1], 0);
    check("t2_bounce_no_held", held_seen1, 1'b0);
    check("t2_bounce_no_any", any_cnt, 0);

    // Long press on ch2.
    clear_mon();
    but_in[2] = 1'b1;
    base = tick_cnt;
    ticks(1500);
    but_in[2] = 1'b0;
    ticks(25);
    check("t3_long_count", long_cnt[2], 1);
    check("t3_long_tick", long_tick[2] - base, 1020);
    check("t3_first_en_tick", en_tick[0 + 2][0] - base, 20);
`ifdef WM_BUT_AUTO_RPT_EN
    check("t3_en_count_rpt", en_cnt[2], 3);
    check("t3_rpt1_tick", en_tick[2][1] - base, 1220);
    check("t3_rpt2_tick", en_tick[2][2] - base, 1420);
`else
    check("t3_en_count_norpt", en_cnt[2], 1);
`endif
    check("t3_held_released", but_held[2], 1'b0);

    // Simultaneous press on ch0 and ch3.
    clear_mon();
    but_in = 4'b1001;
    ticks(20);
    idle_cycle();
    check("t4_en_same_cycle", but_en, 4'b1001);
    check("t4_any_high", but_any, 1'b1);
    idle_cycle();
    check("t4_any_low_after", but_any, 1'b0);
    ticks(5);
    but_in = 4'b0000;
    ticks(25);
    check("t4_any_single_pulse", any_cnt, 1);
    check("t4_en_counts", en_cnt[0] * 16 + en_cnt[3], 17);

    // Reset at tick 10 of a ch0 debounce, with ch3 already accepted and held.
    clear_mon();
    but_in[3] = 1'b1;
    ticks(25);
    check("t5_ch3_held_before_rst", but_held, 4'b1000);
    clear_mon();
    but_in[0] = 1'b1;
    ticks(10);
    @(negedge clk);
    tick  = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("t5_outputs_in_reset", {but_en, but_long, but_held, 3'b000, but_any}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    base = tick_cnt;
    ticks(19);
    check("t5_no_en_before_redebounce", en_cnt[0] + en_cnt[3], 0);
    ticks(1);
    idle_cycle();
    check("t5_en_after_redebounce", but_en, 4'b1001);
    ticks(3);
    check("t5_en_tick", en_tick[0][0] - base, 20);
    but_in = 4'b0000;
    ticks(25);

    // Active-low instance: press, release glitch during HELD, release.
    clear_mon();
    lo_in = 1'b0;
    base = tick_cnt;
    ticks(30);
    check("t6_lo_en_count", lo_en_cnt, 1);
    check("t6_lo_en_tick", lo_en_tick - base, 20);
    check("t6_lo_held", lo_held[0], 1'b1);
    lo_in = 1'b1;
    ticks(3);
    lo_in = 1'b0;
    ticks(1);
    check("t6_lo_held_through_glitch", lo_held[0], 1'b1);
    ticks(5);
    check("t6_lo_no_new_pulse", lo_en_cnt, 1);
    check("t6_lo_no_long", lo_long_cnt, 0);
    lo_in = 1'b1;
    ticks(25);
    check("t6_lo_released", lo_held[0], 1'b0);
    check("t6_hi_quiet", en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
